// File: rtl/control_pipe_if.sv
// ID-stage inputs and per-stage control outputs of the pipelined main-control unit.
// The master modport drives the ID fields; the slave modport is the control unit itself.
interface control_pipe_if #(
    parameter int unsigned OPC_W   = 6,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned OTHER_W = 4,
    parameter int unsigned CNT_W   = 16
);
    logic               i_cpc_valid;
    logic [OPC_W-1:0]   i_cpc_opcode;
    logic [REG_AW-1:0]  i_cpc_rs;
    logic [REG_AW-1:0]  i_cpc_rt;
    logic [REG_AW-1:0]  i_cpc_rd;
    logic               i_cpc_branch_taken;
    logic               i_cpc_mem_stall;

    logic               o_cpc_stall;
    logic               o_cpc_flush;
    logic               o_cpc_ex_valid;
    logic               o_cpc_ex_regdst;
    logic               o_cpc_ex_alusrc;
    logic               o_cpc_ex_illegal;
    logic [1:0]         o_cpc_ex_aluop;
    logic [OTHER_W-1:0] o_cpc_ex_other;
    logic [REG_AW-1:0]  o_cpc_ex_dest;
    logic               o_cpc_mem_valid;
    logic               o_cpc_mem_branch;
    logic               o_cpc_mem_memread;
    logic               o_cpc_mem_memwrite;
    logic               o_cpc_wb_valid;
    logic               o_cpc_wb_regwrite;
    logic               o_cpc_wb_memtoreg;
    logic [CNT_W-1:0]   o_cpc_stall_cnt;
    logic [CNT_W-1:0]   o_cpc_flush_cnt;

    modport master (
        output i_cpc_valid, i_cpc_opcode, i_cpc_rs, i_cpc_rt, i_cpc_rd,
               i_cpc_branch_taken, i_cpc_mem_stall,
        input  o_cpc_stall, o_cpc_flush, o_cpc_ex_valid, o_cpc_ex_regdst, o_cpc_ex_alusrc,
               o_cpc_ex_illegal, o_cpc_ex_aluop, o_cpc_ex_other, o_cpc_ex_dest,
               o_cpc_mem_valid, o_cpc_mem_branch, o_cpc_mem_memread, o_cpc_mem_memwrite,
               o_cpc_wb_valid, o_cpc_wb_regwrite, o_cpc_wb_memtoreg,
               o_cpc_stall_cnt, o_cpc_flush_cnt
    );

    modport slave (
        input  i_cpc_valid, i_cpc_opcode, i_cpc_rs, i_cpc_rt, i_cpc_rd,
               i_cpc_branch_taken, i_cpc_mem_stall,
        output o_cpc_stall, o_cpc_flush, o_cpc_ex_valid, o_cpc_ex_regdst, o_cpc_ex_alusrc,
               o_cpc_ex_illegal, o_cpc_ex_aluop, o_cpc_ex_other, o_cpc_ex_dest,
               o_cpc_mem_valid, o_cpc_mem_branch, o_cpc_mem_memread, o_cpc_mem_memwrite,
               o_cpc_wb_valid, o_cpc_wb_regwrite, o_cpc_wb_memtoreg,
               o_cpc_stall_cnt, o_cpc_flush_cnt
    );
endinterface

// File: rtl/control_pipe.sv
// Pipelined MIPS main control: ID decode, ID/EX, EX/MEM and MEM/WB control registers,
// load-use stall, taken-branch flush, global memory freeze and saturating event counters.
module control_pipe #(
    parameter int unsigned OPC_W   = 6,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned OTHER_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input logic           i_clk,
    input logic           i_rst_n,
    control_pipe_if.slave cpc
);
    typedef struct packed {
        logic               valid;
        logic               regdst;
        logic               regwrite;
        logic               alusrc;
        logic               branch;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic [1:0]         aluop;
        logic [OTHER_W-1:0] other;
        logic [REG_AW-1:0]  dest;
        logic               illegal;
    } idex_t;

    typedef struct packed {
        logic valid;
        logic branch;
        logic memread;
        logic memwrite;
        logic regwrite;
        logic memtoreg;
    } exmem_t;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memtoreg;
    } memwb_t;

    idex_t            dec;
    logic             rt_src;
    idex_t            idex_q, idex_d;
    exmem_t           exmem_q, exmem_d;
    memwb_t           memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             flush;

    always_comb begin
        dec    = '0;
        rt_src = 1'b0;
        casez (cpc.i_cpc_opcode)
            6'b000000: begin
                dec.regdst   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = 2'b10;
                rt_src       = 1'b1;
            end
            6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = 2'b11;
                unique case (cpc.i_cpc_opcode[2:0])
                    3'b100:  dec.other = OTHER_W'(4'b0001);
                    3'b101:  dec.other = OTHER_W'(4'b0010);
                    3'b110:  dec.other = OTHER_W'(4'b0011);
                    3'b010:  dec.other = OTHER_W'(4'b0110);
                    default: dec.other = '0;
                endcase
            end
            6'b100???: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
            end
            6'b101???: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec.memtoreg = 1'b1;
                rt_src       = 1'b1;
            end
            6'b000100: begin
                dec.branch = 1'b1;
                dec.aluop  = 2'b01;
                rt_src     = 1'b1;
            end
            6'b000101: begin
                dec.branch = 1'b1;
                dec.aluop  = 2'b11;
                dec.other  = OTHER_W'(4'b0101);
                rt_src     = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.valid = 1'b1;
        if (dec.regwrite) begin
            dec.dest = dec.regdst ? cpc.i_cpc_rd : cpc.i_cpc_rt;
        end
    end

    assign load_use = idex_q.valid && idex_q.memread && (idex_q.dest != '0) && cpc.i_cpc_valid
                      && ((idex_q.dest == cpc.i_cpc_rs)
                          || ((idex_q.dest == cpc.i_cpc_rt) && rt_src));
    assign flush    = cpc.i_cpc_branch_taken && exmem_q.valid && exmem_q.branch;

    always_comb begin
        idex_d      = idex_q;
        exmem_d     = exmem_q;
        memwb_d     = memwb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!cpc.i_cpc_mem_stall) begin
            memwb_d = '{valid: exmem_q.valid, regwrite: exmem_q.regwrite,
                        memtoreg: exmem_q.memtoreg};
            exmem_d = '{valid: idex_q.valid, branch: idex_q.branch, memread: idex_q.memread,
                        memwrite: idex_q.memwrite, regwrite: idex_q.regwrite,
                        memtoreg: idex_q.memtoreg};
            idex_d  = cpc.i_cpc_valid ? dec : '0;
            // Flush outranks the load-use stall; both drop the ID instruction from ID/EX.
            if (flush) begin
                idex_d  = '0;
                exmem_d = '0;
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else if (load_use) begin
                idex_d = '0;
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign cpc.o_cpc_stall        = cpc.i_cpc_mem_stall || (load_use && !flush);
    assign cpc.o_cpc_flush        = flush && !cpc.i_cpc_mem_stall;
    assign cpc.o_cpc_ex_valid     = idex_q.valid;
    assign cpc.o_cpc_ex_regdst    = idex_q.regdst;
    assign cpc.o_cpc_ex_alusrc    = idex_q.alusrc;
    assign cpc.o_cpc_ex_illegal   = idex_q.illegal;
    assign cpc.o_cpc_ex_aluop     = idex_q.aluop;
    assign cpc.o_cpc_ex_other     = idex_q.other;
    assign cpc.o_cpc_ex_dest      = idex_q.dest;
    assign cpc.o_cpc_mem_valid    = exmem_q.valid;
    assign cpc.o_cpc_mem_branch   = exmem_q.branch;
    assign cpc.o_cpc_mem_memread  = exmem_q.memread;
    assign cpc.o_cpc_mem_memwrite = exmem_q.memwrite;
    assign cpc.o_cpc_wb_valid     = memwb_q.valid;
    assign cpc.o_cpc_wb_regwrite  = memwb_q.regwrite;
    assign cpc.o_cpc_wb_memtoreg  = memwb_q.memtoreg;
    assign cpc.o_cpc_stall_cnt    = stall_cnt_q;
    assign cpc.o_cpc_flush_cnt    = flush_cnt_q;
endmodule
